mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_WAIT_EN, default 1: when 1, memory states wait for mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 pc_write, pc_write_cond  output  1 each  PC update enables, combined downstream as pc_write | (pc_write_cond & zero).
REQ-007 i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  output  1 each  datapath controls.
REQ-008 pc_source, alu_src_b, alu_op  output  2 each  datapath mux and ALU controls.
REQ-009 state  output  4  current state encoding, for debug.
REQ-010 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-011 State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ORIEX=10, ORIWB=11; codes 12-15 go to FETCH on the next edge.
REQ-012 Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, J=000010, ORI=001101.
REQ-013 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ORI->ORIEX, any other->FETCH with illegal_op=1 in this cycle.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if LW, MEMWR if SW.
REQ-016 MEMRD: i_or_d=1, mem_read=1; stay while mem_ready=0, else MEMWB.
REQ-017 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-018 MEMWR: i_or_d=1, mem_write=1; stay while mem_ready=0, else FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; next FETCH.
REQ-021 JUMP: pc_source=10, pc_write=1; next FETCH.
REQ-022 ORIEX: alu_src_a=1, alu_src_b=10, alu_op=11; next ORIWB. ORIWB: reg_dst=0, mem_to_reg=0, reg_write=1; next FETCH.
REQ-023 Every output not listed for a state is 0 in that state; outputs are decoded from state (plus mem_ready where stated), with no extra register stage.
REQ-024 pc_write and pc_write_cond are never both 1 in the same cycle; mem_read and mem_write are never both 1.
REQ-025 opcode is sampled only in DECODE and MEMADR; opcode changes in other states have no effect.
REQ-026 Cycle counts with mem_ready held at 1: LW=5, SW=4, RTYPE=4, ORI=4, BEQ=3, J=3, illegal=2.

Reset
REQ-027 rst_n=0 forces state=FETCH immediately, independent of clk, including in the middle of an instruction or a memory wait.
REQ-028 During reset every output follows the FETCH decode with mem_ready treated as 0: mem_read=1, alu_src_b=01, all other outputs 0, illegal_op=0.
REQ-029 After rst_n deasserts, the first transition happens on the first rising clk edge.

Verification
REQ-030 LW with mem_ready=1: state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-031 SW with mem_ready low for 3 cycles in MEMWR: state stays 5 for 4 cycles; mem_write=1 throughout; next state 0; reg_write never 1.
REQ-032 BEQ then J back-to-back: states 0,1,8,0,1,9,0; pc_write_cond=1 only in 8; pc_write=1 in 9 with pc_source=10.
REQ-033 Opcode 111111 in DECODE: illegal_op=1 for exactly one cycle; next state 0; no reg_write, mem_write or pc_write asserted.
REQ-034 FETCH with mem_ready=0 for 2 cycles, then 1: ir_write and pc_write are 0 for 2 cycles, then 1 for exactly 1 cycle.
REQ-035 rst_n pulsed low mid-cycle in MEMRD: state becomes 0 asynchronously; the bench checks the REQ-028 output values before the next clk edge.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-style control unit: state register plus combinational decode of
// datapath controls from the current state (and mem_ready in memory-wait states).
module mc_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ORIEX  = 4'd10,
    S_ORIWB  = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   ready_c;

  // Reset masks mem_ready so FETCH never strobes ir_write/pc_write while held in reset.
  assign ready_c = rst_n & (MEM_WAIT_EN ? mem_ready : 1'b1);
  assign state   = STATE_W'(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    pc_source     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready_c;
        pc_write  = ready_c;
        state_d   = ready_c ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ORI:       state_d = S_ORIEX;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Opcode is re-sampled here; anything but LW/SW abandons the access.
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        state_d  = ready_c ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = ready_c ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ORIWB;
      end
      S_ORIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed scenarios plus random instruction streams, each
// expanded into an expected state list and checked cycle by cycle against a control table.
module tb_mc_control_fsm;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] JMP   = 6'b000010;
  localparam logic [5:0] ORI   = 6'b001101;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mc_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .pc_source(pc_source), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] obs_vec();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
            reg_write, reg_dst, alu_src_a, pc_source, alu_src_b, alu_op, illegal_op};
  endfunction

  // Control table: what each named step of an instruction must drive.
  function automatic logic [16:0] exp_out(input int st, input bit rdy, input bit ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, il;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, il} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; il = ill; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin iord = 1; mr = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcwc = 1; end
      9:  begin pcs = 2'b10; pcw = 1; end
      10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, asa, pcs, asb, aop, il};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == LW) || (op == SW) || (op == RTYPE) || (op == BEQ) || (op == JMP) || (op == ORI);
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Called at a negedge: drive inputs, check, then advance to the next negedge.
  task automatic step(input int st, input logic [5:0] op, input bit rdy, input bit ill);
    mem_ready = rdy;
    opcode    = (st == 1 || st == 2) ? op : 6'($urandom);
    #1;
    check($sformatf("state cyc=%0d", cyc), 17'(state), 17'(st));
    check($sformatf("ctrl st=%0d cyc=%0d", st, cyc), obs_vec(), exp_out(st, rdy, ill));
    cyc++;
    @(negedge clk);
  endtask

  // Expand one instruction into its state list and walk it, stalling randomly in wait states.
  task automatic run_instr(input logic [5:0] op, input int wait_pct);
    int  q[$];
    bit  rdy;
    bit  waitable;
    int  waits;
    q = {0, 1};
    case (op)
      LW:      q = {q, 2, 3, 4};
      SW:      q = {q, 2, 5};
      RTYPE:   q = {q, 6, 7};
      BEQ:     q = {q, 8};
      JMP:     q = {q, 9};
      ORI:     q = {q, 10, 11};
      default: ;
    endcase
    foreach (q[i]) begin
      waitable = (q[i] == 0) || (q[i] == 3) || (q[i] == 5);
      waits = 0;
      do begin
        if (waitable) rdy = (waits >= 8) ? 1'b1 : (32'($urandom_range(99)) >= 32'(wait_pct));
        else          rdy = 1'($urandom);
        step(q[i], op, rdy, !is_legal(op));
        waits++;
      end while (waitable && !rdy);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [6];
    logic [5:0] r;
    ops = '{LW, SW, RTYPE, BEQ, JMP, ORI};
    if ($urandom_range(6) < 6) return ops[$urandom_range(5)];
    r = 6'b111111;
    for (int t = 0; t < 20; t++) begin
      r = 6'($urandom);
      if (!is_legal(r)) break;
    end
    if (is_legal(r)) r = 6'b111111;
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = LW;

    // Reset: FETCH decode with mem_ready masked even though mem_ready is high.
    #2;
    check("reset state", 17'(state), 17'd0);
    check("reset ctrl", obs_vec(), exp_out(0, 1'b0, 1'b0));
    @(negedge clk);
    check("reset ctrl held", obs_vec(), exp_out(0, 1'b0, 1'b0));
    rst_n = 1'b1;

    run_instr(LW, 0);
    run_instr(BEQ, 0);
    run_instr(JMP, 0);
    run_instr(6'b111111, 0);
    run_instr(RTYPE, 0);
    run_instr(ORI, 0);

    // SW with three stall cycles in MEMWR.
    step(0, SW, 1, 0); step(1, SW, 1, 0); step(2, SW, 1, 0);
    step(5, SW, 0, 0); step(5, SW, 0, 0); step(5, SW, 0, 0); step(5, SW, 1, 0);

    // FETCH stalls two cycles, then a jump.
    step(0, JMP, 0, 0); step(0, JMP, 0, 0); step(0, JMP, 1, 0);
    step(1, JMP, 1, 0); step(9, JMP, 1, 0);

    // Asynchronous reset in the middle of a MEMRD wait.
    step(0, LW, 1, 0); step(1, LW, 1, 0); step(2, LW, 1, 0);
    mem_ready = 1'b0;
    #1;
    check("memrd before reset", 17'(state), 17'd3);
    #1 rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("async reset state", 17'(state), 17'd0);
    check("async reset ctrl", obs_vec(), exp_out(0, 1'b0, 1'b0));
    @(negedge clk);
    check("reset hold state", 17'(state), 17'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) run_instr(pick_op(), 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
